aidc_lite_code_buffer: RTL and testbench
========================================

# aidc_lite_code_buffer

Double-banked block buffer directly downstream of the AIDC-Lite code concatenator. It captures the 64-bit code words the concatenator emits, without backpressure, into one of two banks. It closes a bank when the last word of a block arrives, then drains the completed block with a valid/ready handshake to the memory-side writer, together with its size and an incompressible flag. Double banking lets the concatenator keep producing the next block while the previous one drains.

## Interface
- `DEPTH`, 8: words per bank (8 × 64 = 512-bit line).
- `MAX_BITS`, 512: largest compressed size accepted as a valid block. Above this the block is flagged `fail_o`.
- `clk` in 1: the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `valid_i` in 1: code word valid. No backpressure; it must be accepted or dropped.
- `addr_i` in 4: word index within the block (0 = first word).
- `data_i` in 64: code word, MSB-first bit order.
- `last_i` in 1: final word of the block; qualified by `valid_i`.
- `blk_size_i` in 11: total block size in bits, including the 2-bit prefix; sampled with `last_i`.
- `valid_o` out 1: output word valid.
- `ready_i` in 1: downstream accepts the word.
- `data_o` out 64: output word.
- `addr_o` out 4: index of the output word.
- `last_o` out 1: final word of the drained block.
- `blk_size_o` out 11: size of the draining block; stable for the whole drain.
- `fail_o` out 1: the draining block has `blk_size > MAX_BITS`.
- `overflow_o` out 1: sticky; a word was dropped because no bank was free.

## Operation
- Each bank has a state: EMPTY, FILL, or FULL. It also holds storage `[DEPTH][64]`, an 11-bit size, and a fail bit.
- `wr_bank` is the bank being filled; `rd_bank` is the bank being drained. Both reset to 0.
- **Write** (`valid_i=1`):
  - Target bank EMPTY or FILL:
    - Store `data_i` at `addr_i` and set the bank to FILL.
    - If `addr_i >= DEPTH`, do not store the word. Set the bank's fail bit instead.
  - On `last_i`:
    - Latch `blk_size_i` into the bank.
    - Set fail if `blk_size_i > MAX_BITS` or the fail bit was already set.
    - Set the bank to FULL and toggle `wr_bank`.
  - Target bank FULL: drop the word and set `overflow_o`.
    - Enter a drop state that discards every word up to and including the next `last_i`.
    - Do not toggle `wr_bank` at that `last_i`.
    - This avoids writing a partial block into a bank that is freed mid-block.
- **Drain:**
  - `valid_o = (bank[rd_bank]==FULL)`.
  - `data_o = bank[rd_bank].mem[rd_ptr]` and `addr_o = rd_ptr`.
  - `nwords = min(DEPTH, (blk_size+63)>>6)`, with a minimum of 1.
  - `last_o = valid_o && rd_ptr==nwords-1`.
  - A transfer occurs when `valid_o && ready_i`.
    - On a non-last transfer, `rd_ptr` increments.
    - On a last transfer, `rd_ptr` goes to 0, the bank goes to EMPTY, and `rd_bank` toggles.
  - A failed block still drains `nwords` words. Downstream decides to write the raw line instead.
- **Simultaneous events:**
  - A bank may be freed by the drain and written in the same cycle. The write is accepted, because the freeing takes effect that cycle.
  - The write side may close a bank on the same cycle the drain frees the other bank. Both state updates apply.
- `overflow_o` clears only on reset.

## Timing
- All outputs are registered state or a mux of registered state. There is no combinational path from `valid_i` to any output.
- Latency:
  - A `last_i` at cycle N gives `valid_o=1` at N+1, with `addr_o=0`.
  - Drain throughput is one word per cycle while `ready_i=1`.
- `valid_o` must not drop, and `data_o/addr_o/blk_size_o/fail_o` must not change, while `valid_o && !ready_i`.
- Reset values (applied asynchronously):
  - All banks EMPTY, `wr_bank=rd_bank=0`, `rd_ptr=0`, drop state cleared.
  - `valid_o=0`, `last_o=0`, `overflow_o=0`, `fail_o=0`, `addr_o=0`, `blk_size_o=0`.
  - `data_o` is don't-care.
- A reset mid-fill or mid-drain discards all content. The first word after reset must carry `addr_i=0`.

## Structure
- Shared package `aidc_lite_pkg`:
  - `AIDC_WORD_W=64`.
  - `AIDC_BLK_SIZE_W=11`.
  - `AIDC_PREFIX_W=2`.
  - Bank state enum `{EMPTY, FILL, FULL}`.
  - Function `words_of(blk_size)`.
- One natural sub-module, `aidc_lite_code_bank`. It owns the storage, state, size and fail bit of one bank, and is instantiated twice. The top level holds `wr_bank/rd_bank/rd_ptr`, the drop state and the overflow flag.

## Test plan
- Single block, 2-bit prefix plus a 6-bit code (`blk_size=8`), one word at `addr 0` with `last`, `ready_i=1` → one output word with `addr_o=0`, `last_o=1`, `blk_size_o=8`, `fail_o=0`, appearing one cycle after input.
- 4-word block with `blk_size=200` while `ready_i=0` for 5 cycles → `valid_o` held and data stable; then 4 words drained with `last_o` on `addr_o=3`.
- Block of 9 words with `blk_size=560` → `fail_o=1`; 8 words drained; the word at `addr 8` is not stored; `overflow_o=0`.
- Three back-to-back 1-word blocks with `ready_i=0` → banks 0 and 1 FULL; the third block is dropped and `overflow_o=1`. After `ready_i=1`, exactly the first two blocks drain, in order.
- Drain final word and new `last_i` in the same cycle → no overflow, and the new block appears next without a gap cycle.
- Assert `rst` mid-drain on word 2 of 4 → `valid_o=0` immediately; the next block starts in bank 0 and drains from `addr_o=0`.

Source files
------------

// File: rtl/aidc_lite_pkg.sv
// -----------------------------------------------------------------------------
// aidc_lite_pkg
// Shared definitions for the AIDC-Lite code path: word and size widths, the
// per-bank state encoding used by the code buffer, and the helper that turns
// a compressed block size in bits into the number of 64-bit words it spans.
// -----------------------------------------------------------------------------
package aidc_lite_pkg;

  localparam int AIDC_WORD_W     = 64;
  localparam int AIDC_BLK_SIZE_W = 11;
  localparam int AIDC_PREFIX_W   = 2;
  localparam int AIDC_ADDR_W     = 4;
  // Word count of an 11-bit size is at most 32, so 6 bits are enough.
  localparam int AIDC_NWORDS_W   = AIDC_BLK_SIZE_W - 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } bank_state_e;

  // Words covered by a block of blk_size bits, rounded up, never below one.
  // Not clamped to the bank depth; the caller applies its own depth limit.
  function automatic logic [AIDC_NWORDS_W-1:0] words_of(
    input logic [AIDC_BLK_SIZE_W-1:0] blk_size
  );
    logic [AIDC_BLK_SIZE_W:0] sum;
    sum = {1'b0, blk_size} + (AIDC_BLK_SIZE_W + 1)'(AIDC_WORD_W - 1);
    if (sum[AIDC_BLK_SIZE_W:6] == '0) begin
      return AIDC_NWORDS_W'(1);
    end
    return sum[AIDC_BLK_SIZE_W:6];
  endfunction

endpackage

// File: rtl/aidc_lite_code_bank.sv
// -----------------------------------------------------------------------------
// aidc_lite_code_bank
// One bank of the code buffer: DEPTH x 64-bit storage plus the bank state,
// latched block size and fail bit.
//   clk, rst       : clock, asynchronous active-high reset
//   i_wr_en        : accepted code word targets this bank
//   i_wr_addr/data : word index and code word
//   i_wr_last      : word closes the block (bank goes FULL)
//   i_wr_size      : block size in bits, latched with i_wr_last
//   i_free         : final word of this bank was drained this cycle
//   i_rd_ptr       : word index being presented on the read side
//   o_state        : EMPTY / FILL / FULL
//   o_rd_data      : storage word at i_rd_ptr
//   o_size, o_fail : latched block size and fail flag
// -----------------------------------------------------------------------------
module aidc_lite_code_bank
  import aidc_lite_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int MAX_BITS = 512,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [AIDC_ADDR_W-1:0]     i_wr_addr,
  input  logic [AIDC_WORD_W-1:0]     i_wr_data,
  input  logic                       i_wr_last,
  input  logic [AIDC_BLK_SIZE_W-1:0] i_wr_size,
  input  logic                       i_free,
  input  logic [PTR_W-1:0]           i_rd_ptr,
  output bank_state_e                o_state,
  output logic [AIDC_WORD_W-1:0]     o_rd_data,
  output logic [AIDC_BLK_SIZE_W-1:0] o_size,
  output logic                       o_fail
);

  localparam logic [AIDC_ADDR_W:0]     DEPTH_L  = (AIDC_ADDR_W + 1)'(DEPTH);
  localparam logic [AIDC_BLK_SIZE_W-1:0] MAX_SIZE = AIDC_BLK_SIZE_W'(MAX_BITS);

  logic [AIDC_WORD_W-1:0]     r_mem [DEPTH];
  bank_state_e                r_state;
  logic [AIDC_BLK_SIZE_W-1:0] r_size;
  logic                       r_fail;

  logic w_in_range;
  logic w_fail_base;
  logic w_fail_word;

  assign w_in_range  = {1'b0, i_wr_addr} < DEPTH_L;
  // A bank freed this cycle starts its next block with a clean fail bit, even
  // when the first word of that block lands in the same cycle.
  assign w_fail_base = r_fail & ~i_free;
  assign w_fail_word = w_fail_base | ~w_in_range;

  // NOTE: storage has no reset; the FULL state gates every read, so stale
  // contents are never presented as valid and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en && w_in_range) begin
      r_mem[i_wr_addr[PTR_W-1:0]] <= i_wr_data;
    end
  end

  // NOTE: non-blocking assignments throughout; the later i_wr_en branch wins
  // over i_free so a bank freed and rewritten in one cycle ends up FILL/FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_size  <= '0;
      r_fail  <= 1'b0;
    end else begin
      if (i_free) begin
        r_state <= EMPTY;
        r_fail  <= 1'b0;
      end
      if (i_wr_en) begin
        r_state <= i_wr_last ? FULL : FILL;
        r_fail  <= w_fail_word | (i_wr_last && (i_wr_size > MAX_SIZE));
        if (i_wr_last) begin
          r_size <= i_wr_size;
        end
      end
    end
  end

  assign o_state   = r_state;
  assign o_rd_data = r_mem[i_rd_ptr];
  assign o_size    = r_size;
  assign o_fail    = r_fail;

endmodule

// File: rtl/aidc_lite_code_buffer.sv
// -----------------------------------------------------------------------------
// aidc_lite_code_buffer
// Double-banked block buffer behind the AIDC-Lite code concatenator. Code
// words are written without backpressure into the bank being filled; a closed
// bank is drained with valid/ready together with its size and fail flag.
//   clk, rst        : clock, asynchronous active-high reset
//   valid_i         : code word valid (must be taken or dropped)
//   addr_i, data_i  : word index within block, 64-bit code word
//   last_i          : final word of the block
//   blk_size_i      : block size in bits, sampled with last_i
//   valid_o/ready_i : drain handshake
//   data_o, addr_o  : drained word and its index
//   last_o          : final word of the drained block
//   blk_size_o      : size of the draining block
//   fail_o          : draining block exceeds MAX_BITS or had an out-of-range word
//   overflow_o      : sticky, a word was dropped because no bank was free
// -----------------------------------------------------------------------------
module aidc_lite_code_buffer
  import aidc_lite_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int MAX_BITS = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_i,
  input  logic [AIDC_ADDR_W-1:0]     addr_i,
  input  logic [AIDC_WORD_W-1:0]     data_i,
  input  logic                       last_i,
  input  logic [AIDC_BLK_SIZE_W-1:0] blk_size_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [AIDC_WORD_W-1:0]     data_o,
  output logic [AIDC_ADDR_W-1:0]     addr_o,
  output logic                       last_o,
  output logic [AIDC_BLK_SIZE_W-1:0] blk_size_o,
  output logic                       fail_o,
  output logic                       overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [AIDC_NWORDS_W-1:0] DEPTH_N = AIDC_NWORDS_W'(DEPTH);

  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_drop;
  logic             r_overflow;

  bank_state_e                w_state   [2];
  logic [AIDC_WORD_W-1:0]     w_rd_data [2];
  logic [AIDC_BLK_SIZE_W-1:0] w_size    [2];
  logic                       w_fail    [2];
  logic [1:0]                 w_wr_en;
  logic [1:0]                 w_free;

  logic                     w_valid;
  logic                     w_last;
  logic                     w_xfer;
  logic                     w_tgt_full;
  logic                     w_accept;
  logic                     w_reject;
  logic [AIDC_NWORDS_W-1:0] w_nwords_raw;
  logic [AIDC_NWORDS_W-1:0] w_nwords;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    aidc_lite_code_bank #(
      .DEPTH    (DEPTH),
      .MAX_BITS (MAX_BITS)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en[b]),
      .i_wr_addr (addr_i),
      .i_wr_data (data_i),
      .i_wr_last (last_i),
      .i_wr_size (blk_size_i),
      .i_free    (w_free[b]),
      .i_rd_ptr  (r_rd_ptr),
      .o_state   (w_state[b]),
      .o_rd_data (w_rd_data[b]),
      .o_size    (w_size[b]),
      .o_fail    (w_fail[b])
    );
  end

  // NOTE: every always_comb output gets a default first so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    w_free       = 2'b00;
    w_wr_en      = 2'b00;
    w_valid      = (w_state[r_rd_bank] == FULL);
    w_nwords_raw = words_of(w_size[r_rd_bank]);
    // A failed block can claim more words than a bank holds; drain only DEPTH.
    w_nwords     = (w_nwords_raw > DEPTH_N) ? DEPTH_N : w_nwords_raw;
    w_last       = w_valid && (AIDC_NWORDS_W'(r_rd_ptr) == w_nwords - AIDC_NWORDS_W'(1));
    w_xfer       = w_valid && ready_i;
    if (w_xfer && w_last) begin
      w_free[r_rd_bank] = 1'b1;
    end
    // A bank released by the drain this cycle is already free to the writer.
    w_tgt_full   = (w_state[r_wr_bank] == FULL) && !w_free[r_wr_bank];
    w_accept     = valid_i && !r_drop && !w_tgt_full;
    w_reject     = valid_i && !r_drop && w_tgt_full;
    if (w_accept) begin
      w_wr_en[r_wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_rd_ptr   <= '0;
      r_drop     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_xfer) begin
        if (w_last) begin
          r_rd_ptr  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        end
      end
      if (w_accept && last_i) begin
        r_wr_bank <= ~r_wr_bank;
      end
      // Once a word is dropped, the rest of that block is discarded too so a
      // bank freed mid-block never receives a partial block.
      if (w_reject) begin
        r_overflow <= 1'b1;
        r_drop     <= ~last_i;
      end else if (valid_i && r_drop && last_i) begin
        r_drop     <= 1'b0;
      end
    end
  end

  assign valid_o    = w_valid;
  assign data_o     = w_rd_data[r_rd_bank];
  assign addr_o     = AIDC_ADDR_W'(r_rd_ptr);
  assign last_o     = w_last;
  assign blk_size_o = w_valid ? w_size[r_rd_bank] : '0;
  assign fail_o     = w_valid & w_fail[r_rd_bank];
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_aidc_lite_code_buffer.sv
module tb_aidc_lite_code_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [3:0]  addr_i = '0;
  logic [63:0] data_i = '0;
  logic        last_i = 1'b0;
  logic [10:0] blk_size_i = '0;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [63:0] data_o;
  logic [3:0]  addr_o;
  logic        last_o;
  logic [10:0] blk_size_o;
  logic        fail_o;
  logic        overflow_o;

  int n_tests = 0;
  int n_fail  = 0;

  aidc_lite_code_buffer #(.DEPTH(8), .MAX_BITS(512)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .last_i     (last_i),
    .blk_size_i (blk_size_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .addr_o     (addr_o),
    .last_o     (last_o),
    .blk_size_o (blk_size_o),
    .fail_o     (fail_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of completed blocks (at most two can be held),
  // the block being assembled, a read index into the head block, and flags.
  typedef struct packed {
    logic [7:0][63:0] w;
    logic [7:0]       m;     // which words were actually written
    logic [10:0]      size;
    logic             fail;
  } blk_t;

  blk_t q[$];
  blk_t cur;
  int   rdidx;
  bit   m_drop;
  bit   m_ovf;

  function automatic int words_ref(input int size);
    int n;
    n = (size + 63) / 64;
    if (n > 8) n = 8;
    if (n < 1) n = 1;
    return n;
  endfunction

  task automatic model_clear();
    q.delete();
    cur    = '0;
    rdidx  = 0;
    m_drop = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step(input bit v, input logic [3:0] a, input logic [63:0] d,
                            input bit l, input logic [10:0] s, input bit r);
    bit xfer;
    bit xlast;
    bit push;
    xfer  = (q.size() > 0) && r;
    xlast = 1'b0;
    push  = 1'b0;
    if (xfer) xlast = (rdidx == words_ref(int'(q[0].size)) - 1);
    if (v) begin
      if (m_drop) begin
        if (l) m_drop = 1'b0;
      end else if (q.size() - (xlast ? 1 : 0) == 2) begin
        m_ovf  = 1'b1;
        m_drop = !l;
      end else begin
        if (a < 4'd8) begin
          cur.w[a[2:0]] = d;
          cur.m[a[2:0]] = 1'b1;
        end else begin
          cur.fail = 1'b1;
        end
        if (l) begin
          cur.size = s;
          if (s > 11'd512) cur.fail = 1'b1;
          push = 1'b1;
        end
      end
    end
    if (xfer) begin
      if (xlast) begin
        void'(q.pop_front());
        rdidx = 0;
      end else begin
        rdidx++;
      end
    end
    if (push) begin
      q.push_back(cur);
      cur = '0;
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge, and return at the next falling edge with outputs settled.
  task automatic tick(input bit v, input logic [3:0] a, input logic [63:0] d,
                      input bit l, input logic [10:0] s, input bit r);
    valid_i    = v;
    addr_i     = a;
    data_i     = d;
    last_i     = l;
    blk_size_i = s;
    ready_i    = r;
    @(posedge clk);
    model_step(v, a, d, l, s, r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    valid_i = 1'b0;
    last_i  = 1'b0;
    ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", valid_o); end
    n_tests++; if (last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0h want 0", last_o); end
    n_tests++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0h want 0", overflow_o); end
    n_tests++; if (fail_o !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %0h want 0", fail_o); end
    n_tests++; if (addr_o !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", addr_o); end
    n_tests++; if (blk_size_o !== 11'd0) begin n_fail++; $display("FAIL reset_size: got %0d want 0", blk_size_o); end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_single();
    logic [63:0] d;
    do_reset();
    d = rnd64();
    tick(1, 4'd0, d, 1, 11'd8, 1);
    n_tests++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0h want 1", valid_o); end
    n_tests++; if (addr_o !== 4'd0) begin n_fail++; $display("FAIL single_addr: got %0h want 0", addr_o); end
    n_tests++; if (last_o !== 1'b1) begin n_fail++; $display("FAIL single_last: got %0h want 1", last_o); end
    n_tests++; if (blk_size_o !== 11'd8) begin n_fail++; $display("FAIL single_size: got %0d want 8", blk_size_o); end
    n_tests++; if (fail_o !== 1'b0) begin n_fail++; $display("FAIL single_fail: got %0h want 0", fail_o); end
    n_tests++; if (data_o !== d) begin n_fail++; $display("FAIL single_data: got %h want %h", data_o, d); end
    tick(0, 4'd0, 64'd0, 0, 11'd0, 1);
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_done: got %0h want 0", valid_o); end
  endtask

  task automatic test_stall();
    logic [63:0] d [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d[i] = rnd64();
      tick(1, 4'(i), d[i], i == 3, 11'd200, 0);
    end
    n_tests++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_latency: got %0h want 1", valid_o); end
    for (int c = 0; c < 5; c++) begin
      tick(0, 4'd0, 64'd0, 0, 11'd0, 0);
      n_tests++;
      if (valid_o !== 1'b1 || data_o !== d[0] || addr_o !== 4'd0 || blk_size_o !== 11'd200) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%0h a=%0h d=%h sz=%0d want v=1 a=0 d=%h sz=200",
                 valid_o, addr_o, data_o, blk_size_o, d[0]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (valid_o !== 1'b1 || addr_o !== 4'(i) || data_o !== d[i] || last_o !== (i == 3)) begin
        n_fail++;
        $display("FAIL stall_drain: got v=%0h a=%0h l=%0h d=%h want v=1 a=%0h l=%0h d=%h",
                 valid_o, addr_o, last_o, data_o, i, (i == 3), d[i]);
      end
      tick(0, 4'd0, 64'd0, 0, 11'd0, 1);
    end
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got %0h want 0", valid_o); end
  endtask

  task automatic test_fail_block();
    logic [63:0] d [9];
    do_reset();
    for (int i = 0; i < 9; i++) begin
      d[i] = rnd64();
      tick(1, 4'(i), d[i], i == 8, 11'd560, 0);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (valid_o !== 1'b1 || fail_o !== 1'b1 || addr_o !== 4'(i) || data_o !== d[i] ||
          last_o !== (i == 7) || blk_size_o !== 11'd560) begin
        n_fail++;
        $display("FAIL failblk_drain: got v=%0h f=%0h a=%0h l=%0h sz=%0d d=%h want v=1 f=1 a=%0h l=%0h sz=560 d=%h",
                 valid_o, fail_o, addr_o, last_o, blk_size_o, data_o, i, (i == 7), d[i]);
      end
      tick(0, 4'd0, 64'd0, 0, 11'd0, 1);
    end
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL failblk_empty: got %0h want 0", valid_o); end
    n_tests++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL failblk_overflow: got %0h want 0", overflow_o); end
  endtask

  task automatic test_overflow();
    logic [63:0] d [3];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      d[k] = rnd64();
      tick(1, 4'd0, d[k], 1, 11'd8, 0);
    end
    n_tests++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0h want 1", overflow_o); end
    n_tests++; if (data_o !== d[0]) begin n_fail++; $display("FAIL ovf_first: got %h want %h", data_o, d[0]); end
    tick(0, 4'd0, 64'd0, 0, 11'd0, 1);
    n_tests++; if (valid_o !== 1'b1 || data_o !== d[1]) begin
      n_fail++; $display("FAIL ovf_second: got v=%0h d=%h want v=1 d=%h", valid_o, data_o, d[1]);
    end
    tick(0, 4'd0, 64'd0, 0, 11'd0, 1);
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL ovf_third_dropped: got %0h want 0", valid_o); end
    n_tests++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0h want 1", overflow_o); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] da, db, dc;
    do_reset();
    da = rnd64(); db = rnd64(); dc = rnd64();
    tick(1, 4'd0, da, 1, 11'd8, 0);
    tick(1, 4'd0, db, 1, 11'd8, 0);
    // Both banks full: C arrives exactly as A's final word leaves.
    tick(1, 4'd0, dc, 1, 11'd8, 1);
    n_tests++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %0h want 0", overflow_o); end
    n_tests++; if (valid_o !== 1'b1 || data_o !== db) begin
      n_fail++; $display("FAIL b2b_second: got v=%0h d=%h want v=1 d=%h", valid_o, data_o, db);
    end
    tick(0, 4'd0, 64'd0, 0, 11'd0, 1);
    n_tests++; if (valid_o !== 1'b1 || data_o !== dc || last_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_third: got v=%0h l=%0h d=%h want v=1 l=1 d=%h", valid_o, last_o, data_o, dc);
    end
    tick(0, 4'd0, 64'd0, 0, 11'd0, 1);
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %0h want 0", valid_o); end
  endtask

  task automatic test_reset_mid_drain();
    logic [63:0] d;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 4'(i), rnd64(), i == 3, 11'd200, 0);
    tick(0, 4'd0, 64'd0, 0, 11'd0, 1);
    tick(0, 4'd0, 64'd0, 0, 11'd0, 1);
    n_tests++; if (addr_o !== 4'd2) begin n_fail++; $display("FAIL rstmid_pre: got %0h want 2", addr_o); end
    rst = 1'b1;
    #1;
    n_tests++; if (valid_o !== 1'b0 || addr_o !== 4'd0) begin
      n_fail++; $display("FAIL rstmid_async: got v=%0h a=%0h want v=0 a=0", valid_o, addr_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    d = rnd64();
    tick(1, 4'd0, d, 1, 11'd8, 0);
    n_tests++; if (valid_o !== 1'b1 || addr_o !== 4'd0 || data_o !== d) begin
      n_fail++; $display("FAIL rstmid_next: got v=%0h a=%0h d=%h want v=1 a=0 d=%h", valid_o, addr_o, data_o, d);
    end
    tick(0, 4'd0, 64'd0, 0, 11'd0, 1);
  endtask

  task automatic test_random();
    int          idx;
    int          len;
    logic [10:0] sz;
    blk_t        b;
    int          nw;
    do_reset();
    idx = 0;
    len = 1;
    sz  = 11'd8;
    for (int c = 0; c < 440; c++) begin
      bit          v;
      bit          l;
      bit          r;
      logic [3:0]  a;
      v = (c < 400) && ($urandom_range(0, 3) != 0);
      r = (c >= 400) || ($urandom_range(0, 2) != 0);
      l = 1'b0;
      a = 4'd0;
      if (v) begin
        if (idx == 0) begin
          len = $urandom_range(1, 9);
          sz  = 11'($urandom_range(1, 700));
        end
        a   = 4'(idx);
        l   = (idx == len - 1);
        idx = l ? 0 : idx + 1;
      end
      tick(v, a, rnd64(), l, sz, r);
      n_tests++;
      if (valid_o !== (q.size() > 0)) begin
        n_fail++; $display("FAIL rnd_valid c=%0d: got %0h want %0h", c, valid_o, (q.size() > 0));
      end
      n_tests++;
      if (overflow_o !== m_ovf) begin
        n_fail++; $display("FAIL rnd_overflow c=%0d: got %0h want %0h", c, overflow_o, m_ovf);
      end
      if (q.size() > 0) begin
        b  = q[0];
        nw = words_ref(int'(b.size));
        n_tests++;
        if (addr_o !== 4'(rdidx) || last_o !== (rdidx == nw - 1) ||
            blk_size_o !== b.size || fail_o !== b.fail) begin
          n_fail++;
          $display("FAIL rnd_ctrl c=%0d: got a=%0h l=%0h sz=%0d f=%0h want a=%0h l=%0h sz=%0d f=%0h",
                   c, addr_o, last_o, blk_size_o, fail_o, rdidx, (rdidx == nw - 1), b.size, b.fail);
        end
        if (b.m[3'(rdidx)]) begin
          n_tests++;
          if (data_o !== b.w[3'(rdidx)]) begin
            n_fail++; $display("FAIL rnd_data c=%0d: got %h want %h", c, data_o, b.w[3'(rdidx)]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_fail_block();
    test_overflow();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
